// File: rtl/temp_conv_pkg.sv
// rtl/temp_conv_pkg.sv - shared states and constants for the temperature conversion controller
package temp_conv_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ARM,
    ST_MEASURE,
    ST_ACCUM,
    ST_DONE
  } state_t;

  localparam int COUNT_MAX = 255;
  localparam int ACC_W     = 11;
endpackage

// File: rtl/temp_conv_ctrl_if.sv
// rtl/temp_conv_ctrl_if.sv - result channel: averaged count, overflow flag, valid/ready handshake
interface temp_conv_ctrl_if;
  logic [7:0] result;
  logic       result_valid;
  logic       result_ready;
  logic       ovf;

  modport master (output result, output result_valid, output ovf, input result_ready);
  modport slave  (input result, input result_valid, input ovf, output result_ready);
endinterface

// File: rtl/cmp_sync_edge.sv
// rtl/cmp_sync_edge.sv - two-flop synchronizer for the comparator plus rising-edge detect
module cmp_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);
  // [0],[1] form the synchronizer; [2] is the previous synchronized value
  logic [2:0] sh_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh_q <= '0;
    else        sh_q <= {sh_q[1:0], async_i};
  end

  assign rise_o = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/temp_conv_ctrl.sv
// rtl/temp_conv_ctrl.sv - settle/arm/measure sequencer that averages 2^cfg_avg comparator timings
module temp_conv_ctrl
  import temp_conv_pkg::*;
#(
  parameter int AVG_MAX_LOG2 = 3,
  parameter int ARM_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] cfg_avg,
  input  logic [7:0] cfg_settle,
  input  logic       cmp_out,
  output logic       sens_en,
  output logic       cap_rst,
  output logic       busy,
  temp_conv_ctrl_if.master res
);
  localparam int IDX_W = AVG_MAX_LOG2 + 1;

  state_t             state_q, state_d;
  logic [1:0]         avg_q, avg_d;
  logic [7:0]         settle_q, settle_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]         sample_q, sample_d;
  logic [7:0]         result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               cmp_rise;

  logic [ACC_W-1:0]   acc_sum;
  logic [IDX_W-1:0]   idx_inc;
  logic [IDX_W-1:0]   n_samples;

  cmp_sync_edge u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (cmp_out),
    .rise_o  (cmp_rise)
  );

  assign acc_sum   = acc_q + ACC_W'(sample_q);
  assign idx_inc   = idx_q + IDX_W'(1);
  assign n_samples = IDX_W'(1) << avg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      avg_q    <= '0;
      settle_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      sample_q <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      avg_q    <= avg_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      sample_q <= sample_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    avg_d    = avg_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    sample_d = sample_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    sens_en  = 1'b0;
    cap_rst  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          avg_d    = cfg_avg;
          settle_d = cfg_settle;
          acc_d    = '0;
          idx_d    = '0;
          ovf_d    = 1'b0;
          cnt_d    = '0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        sens_en = 1'b1;
        // a zero settle still spends one cycle here
        if (settle_q == 8'd0 || cnt_q == settle_q - 8'd1) begin
          cnt_d   = '0;
          state_d = ST_ARM;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_ARM: begin
        sens_en = 1'b1;
        cap_rst = 1'b1;
        if (cnt_q == 8'(ARM_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_MEASURE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_MEASURE: begin
        sens_en = 1'b1;
        if (cmp_rise) begin
          sample_d = cnt_q;
          state_d  = ST_ACCUM;
        end else if (cnt_q == 8'(COUNT_MAX)) begin
          sample_d = 8'(COUNT_MAX);
          ovf_d    = 1'b1;
          state_d  = ST_ACCUM;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_ACCUM: begin
        sens_en = 1'b1;
        acc_d   = acc_sum;
        idx_d   = idx_inc;
        cnt_d   = '0;
        if (idx_inc == n_samples) begin
          result_d = 8'(acc_sum >> avg_q);
          state_d  = ST_DONE;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_DONE: begin
        if (res.result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy             = (state_q != ST_IDLE);
  assign res.result       = result_q;
  assign res.result_valid = (state_q == ST_DONE);
  assign res.ovf          = ovf_q;
endmodule

// File: tb/tb_temp_conv_ctrl.sv
// tb/tb_temp_conv_ctrl.sv - directed and randomized conversions checked against an arithmetic model
module tb_temp_conv_ctrl;
  localparam int ARM = 4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] cfg_avg;
  logic [7:0] cfg_settle;
  logic       cmp_out;
  logic       sens_en;
  logic       cap_rst;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  temp_conv_ctrl_if res_if ();

  temp_conv_ctrl #(.AVG_MAX_LOG2(3), .ARM_CYCLES(ARM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .cfg_avg    (cfg_avg),
    .cfg_settle (cfg_settle),
    .cmp_out    (cmp_out),
    .sens_en    (sens_en),
    .cap_rst    (cap_rst),
    .busy       (busy),
    .res        (res_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // d[k] is the measure count at which sample k's comparator rise should register;
  // values above 255 mean the comparator never rises and the sample times out.
  task automatic run_conv(input string tag, input int avg, input int settle,
                          input int d[8], input int hold);
    int  n = 1 << avg;
    int  exp_sum = 0;
    bit  exp_ovf = 0;
    int  exp_res;
    int  exp_settle;
    int  cycles = 0, pulses = 0, bad_len = 0, settle_cnt = 0, len = 0, pos = 0;
    int  unstable = 0;
    bit  raised = 1, prev_cap = 0;

    for (int k = 0; k < n; k++) begin
      if (d[k] > 255) begin
        exp_sum += 255;
        exp_ovf = 1;
      end else begin
        exp_sum += d[k];
      end
    end
    exp_res    = exp_sum / n;
    exp_settle = (settle == 0) ? 1 : settle;

    @(negedge clk);
    start      = 1'b1;
    cfg_avg    = 2'(avg);
    cfg_settle = 8'(settle);
    @(negedge clk);
    start      = 1'b0;
    cfg_avg    = 2'($urandom);
    cfg_settle = 8'($urandom);
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);

    while (!res_if.result_valid && cycles < 5000) begin
      if (cap_rst && !prev_cap) begin
        pulses++;
        len     = 0;
        cmp_out = 1'b0;
        pos     = -ARM;
        raised  = 0;
      end else begin
        pos++;
      end
      if (cap_rst) len++;
      if (!cap_rst && prev_cap && len != ARM) bad_len++;
      if (sens_en && pulses == 0) settle_cnt++;
      // synchronizer adds two cycles between the pin edge and the sampled count
      if (!raised && pulses > 0 && pulses <= n && d[pulses-1] <= 255 && pos == d[pulses-1] - 2) begin
        cmp_out = 1'b1;
        raised  = 1;
      end
      start    = ($urandom_range(0, 15) == 0);
      prev_cap = cap_rst;
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;

    chk({tag, "_valid"},    32'(res_if.result_valid), 32'd1);
    chk({tag, "_result"},   32'(res_if.result), 32'(exp_res));
    chk({tag, "_ovf"},      32'(res_if.ovf), 32'(exp_ovf));
    chk({tag, "_pulses"},   32'(pulses), 32'(n));
    chk({tag, "_pulse_len"}, 32'(bad_len), 32'd0);
    chk({tag, "_settle"},   32'(settle_cnt), 32'(exp_settle));
    chk({tag, "_done_out"}, {29'd0, sens_en, cap_rst, busy}, 32'd1);

    for (int i = 0; i < hold; i++) begin
      start = $urandom_range(0, 1);
      @(negedge clk);
      if (res_if.result !== 8'(exp_res) || res_if.ovf !== exp_ovf ||
          res_if.result_valid !== 1'b1 || busy !== 1'b1) unstable++;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, 32'(unstable), 32'd0);

    start               = 1'b0;
    res_if.result_ready = 1'b1;
    @(negedge clk);
    res_if.result_ready = 1'b0;
    chk({tag, "_idle"}, {30'd0, res_if.result_valid, busy}, 32'd0);
    chk({tag, "_idle_hold"}, {23'd0, res_if.ovf, res_if.result}, {23'd0, exp_ovf, 8'(exp_res)});
  endtask

  initial begin
    int d[8];
    int cyc;
    bit found;

    rst_n = 1'b0;
    start = 1'b0;
    cfg_avg = '0;
    cfg_settle = '0;
    cmp_out = 1'b0;
    res_if.result_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {26'd0, sens_en, cap_rst, busy, res_if.result_valid, res_if.ovf, 1'b0},
        32'd0);
    chk("rst_result", 32'(res_if.result), 32'd0);
    rst_n = 1'b1;

    d = '{100, 0, 0, 0, 0, 0, 0, 0};
    run_conv("single", 0, 10, d, 0);

    d = '{40, 42, 44, 46, 0, 0, 0, 0};
    run_conv("avg4", 2, 7, d, 0);

    d = '{300, 300, 300, 300, 300, 300, 300, 300};
    run_conv("timeout8", 3, 3, d, 0);

    d = '{60, 70, 0, 0, 0, 0, 0, 0};
    run_conv("hold", 1, 2, d, 20);

    // reset in the middle of a measurement
    @(negedge clk);
    start = 1'b1;
    cfg_avg = 2'd1;
    cfg_settle = 8'd3;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    cyc = 0;
    while (!found && cyc < 100) begin
      @(negedge clk);
      if (cap_rst) begin
        @(negedge clk);
        while (cap_rst && cyc < 100) begin
          @(negedge clk);
          cyc++;
        end
        found = !cap_rst;
      end
      cyc++;
    end
    chk("rst_mid_reached", 32'(found), 32'd1);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {27'd0, sens_en, cap_rst, busy, res_if.result_valid, res_if.ovf},
        32'd0);
    chk("rst_mid_result", 32'(res_if.result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    d = '{50, 0, 0, 0, 0, 0, 0, 0};
    run_conv("after_rst", 0, 5, d, 0);

    d = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_conv("first_cycle", 0, 0, d, 0);
    d = '{1, 255, 0, 0, 0, 0, 0, 0};
    run_conv("edge_counts", 1, 0, d, 2);

    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < 8; k++) d[k] = $urandom_range(0, 270);
      run_conv($sformatf("rand%0d", t), $urandom_range(0, 3), $urandom_range(0, 20), d,
               $urandom_range(0, 5));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/temp_conv_ctrl.md
TEMP_CONV_CTRL -- requirements
Module: temp_conv_ctrl

Interface
REQ-001 Parameter: AVG_MAX_LOG2, default 3, maximum log2 of the averaging count.
REQ-002 Parameter: ARM_CYCLES, default 4, number of cycles cap_rst is held before each sample.
REQ-003 Port: clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: start  input  1  one-cycle conversion request; sampled only in IDLE.
REQ-006 Port: cfg_avg  input  2  log2 of samples per conversion (0..3 -> 1,2,4,8); latched on accepted start.
REQ-007 Port: cfg_settle  input  8  sensor settle cycles after enable; latched on accepted start.
REQ-008 Port: cmp_out  input  1  asynchronous comparator output from analog sensor.
REQ-009 Port: sens_en  output  1  analog sensor/oscillator enable.
REQ-010 Port: cap_rst  output  1  capacitor discharge strobe to sensor.
REQ-011 Port: busy  output  1  high in every state except IDLE.
REQ-012 Port: result  output  8  averaged sample count.
REQ-013 Port: result_valid  output  1  result available; held until accepted.
REQ-014 Port: result_ready  input  1  consumer acceptance.
REQ-015 Port: ovf  output  1  at least one sample in the conversion saturated; valid with result.

Function
REQ-016 cmp_out SHALL pass a 2-flop synchronizer; a rising edge (cmp_rise) SHALL be detected on the synchronized signal (3 cycles worst-case latency).
REQ-017 FSM states: IDLE, SETTLE, ARM, MEASURE, ACCUM, DONE.
REQ-018 IDLE -> SETTLE on start=1; latch cfg_avg and cfg_settle, clear the accumulator, sample index and ovf.
REQ-019 SETTLE: sens_en=1; count cfg_settle cycles, then -> ARM; cfg_settle=0 SHALL go to ARM on the next cycle.
REQ-020 ARM: cap_rst=1 for exactly ARM_CYCLES cycles, then -> MEASURE with the sample counter at 0.
REQ-021 MEASURE: counter increments by 1 per cycle; on cmp_rise the sample equals the counter value on that cycle -> ACCUM.
REQ-022 MEASURE timeout: when the counter reaches 255 without cmp_rise, the sample SHALL be 255, ovf SHALL set (sticky for the conversion) -> ACCUM.
REQ-023 A cmp_rise in the first MEASURE cycle SHALL give sample 0.
REQ-024 ACCUM: add the sample into an 11-bit accumulator and increment the index; if index < 2^cfg_avg -> ARM, else -> DONE.
REQ-025 The accumulator SHALL never overflow (8 x 255 = 2040 < 2048).
REQ-026 DONE: result = accumulator >> cfg_avg (truncating); result_valid=1, sens_en=0; -> IDLE on the cycle result_valid & result_ready.
REQ-027 result and ovf SHALL hold stable while result_valid=1 and hold their last value in IDLE.
REQ-028 sens_en=1 in SETTLE, ARM, MEASURE and ACCUM only; cap_rst=1 in ARM only.
REQ-029 start SHALL be ignored in every state other than IDLE, including DONE.
REQ-030 cmp_rise outside MEASURE SHALL be ignored.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, with result=0, result_valid=0, ovf=0, sens_en=0, cap_rst=0, busy=0, and all counters and synchronizer flops at 0.
REQ-032 Reset mid-conversion SHALL discard partial data; the first conversion after release SHALL be unaffected.

Structure
REQ-033 Package temp_conv_pkg SHALL hold the state enum, COUNT_MAX=255 and the accumulator width constant.
REQ-034 One sub-module, cmp_sync_edge (2-flop synchronizer plus rising-edge detector), SHALL be instantiated once.

Verification
REQ-035 cfg_avg=0, cfg_settle=10, cmp rise 100 cycles after MEASURE entry (allowing for sync latency) -> result within 100..103, ovf=0, single conversion.
REQ-036 cfg_avg=2, rise delays 40/42/44/46 -> accumulator 172 ±sync offset, result=43 ±1, exactly 4 cap_rst pulses of 4 cycles each.
REQ-037 cmp_out held low, cfg_avg=3 -> result=255, ovf=1, conversion ends after 8 timeouts.
REQ-038 result_ready held low 20 cycles in DONE with start pulses -> result stable, start ignored, busy=1; ready=1 -> IDLE next cycle.
REQ-039 rst_n pulsed low mid-MEASURE -> all outputs 0 asynchronously; next conversion with a 50-cycle delay -> result 50..53.
REQ-040 cfg_settle=0 and cmp rise in the first MEASURE cycle -> SETTLE lasts one cycle, sample=0, no lockup.
